// File: rtl/tcam_req_ctrl_pkg.sv
// Shared types and field positions for the TCAM request sequencer.
package tcam_pkg;

   // Layout of the TCAM result word: [5]=hit, [4:0]=index, [31:6] must be 0
   localparam int HIT_BIT = 5;
   localparam int IDX_LSB = 0;
   localparam int IDX_W   = 5;
   localparam int PORT_W  = 32;
   localparam int RSP_W   = IDX_W + 2;

   // One request as registered onto the TCAM port
   typedef struct packed {
      logic              we;
      logic [3:0]        wmask;
      logic [PORT_W-1:0] key;
      logic [PORT_W-1:0] wdata;
   } tcam_cmd_t;

   // One buffered search response
   typedef struct packed {
      logic             err;
      logic             hit;
      logic [IDX_W-1:0] idx;
   } tcam_rsp_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WR_GAP = 2'd2
   } tcam_state_e;

   // Split a raw result word into the response fields; any stray upper bit flags err
   function automatic tcam_rsp_t decode_result(input logic [PORT_W-1:0] rdata);
      tcam_rsp_t r;
      r.err = |rdata[PORT_W-1:HIT_BIT+1];
      r.hit = rdata[HIT_BIT];
      r.idx = rdata[IDX_LSB +: IDX_W];
      return r;
   endfunction

endpackage

// File: rtl/tcam_req_ctrl_rsp_fifo.sv
// Register-based first-word-fall-through FIFO with occupancy count.
module tcam_rsp_fifo #(
   parameter int W     = 7,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;

   // Qualify push/pop; a push into a full FIFO is only taken alongside a pop
   always_comb begin
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because empty masks the output
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // Head entry falls through; forced to zero while empty so outputs are clean
   always_comb begin
      dout_o = '0;
      if (!empty_o) begin
         dout_o = mem_q[rd_ptr_q];
      end
   end

endmodule

// File: rtl/tcam_req_ctrl.sv
// Request sequencer in front of the TCAM: issues searches/writes from
// registers, tracks in-flight searches and buffers their results.
module tcam_req_ctrl
   import tcam_pkg::*;
#(
   parameter int KEY_W      = 28,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1,
   parameter int RSP_DEPTH  = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [3:0]        req_wmask_i,
   input  logic [KEY_W-1:0]  req_key_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              tcam_csb_o,
   output logic              tcam_web_o,
   output logic [3:0]        tcam_wmask_o,
   output logic [31:0]       tcam_addr_o,
   output logic [DATA_W-1:0] tcam_wdata_o,
   input  logic [31:0]       tcam_rdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic              rsp_hit_o,
   output logic [4:0]        rsp_index_o,
   output logic              rsp_err_o,
   output logic [CNT_W-1:0]  stat_search_o,
   output logic [CNT_W-1:0]  stat_hit_o,
   output logic              busy_o
);

   localparam int FIFO_AW = $clog2(RSP_DEPTH);

   tcam_state_e           state_q, state_d;
   tcam_cmd_t             cmd_q, cmd_d;
   logic                  csb_q, csb_d;
   logic                  web_q, web_d;
   logic [RD_LATENCY-1:0] pipe_q, pipe_d;
   logic [CNT_W-1:0]      stat_search_q, stat_search_d;
   logic [CNT_W-1:0]      stat_hit_q, stat_hit_d;

   logic                  accept;
   logic                  issue_search;
   logic                  issue_write;
   logic                  push;
   logic [7:0]            inflight;
   logic [7:0]            used;
   tcam_rsp_t             rsp_in, rsp_out;
   logic [RSP_W-1:0]      fifo_dout;
   logic                  fifo_full, fifo_empty;
   logic [FIFO_AW:0]      fifo_count;

   assign accept       = req_valid_i && req_ready_o;
   assign issue_search = (state_q == ISSUE) && !cmd_q.we;
   assign issue_write  = (state_q == ISSUE) && cmd_q.we;
   assign push         = pipe_q[RD_LATENCY-1];

   // Count searches that hold a credit but have not yet reached the FIFO
   always_comb begin
      inflight = 8'(issue_search);
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + 8'(pipe_q[i]);
      end
      used = inflight + 8'(fifo_count);
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: searches may stream back-to-back, a write always takes a gap cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE: begin
            if (cmd_q.we)    state_d = WR_GAP;
            else if (accept) state_d = ISSUE;
            else             state_d = IDLE;
         end
         WR_GAP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM output: credit-based ready. It is also held low while a write is on the
   // port so that nothing can be accepted that would have to skip the write gap.
   always_comb begin
      req_ready_o = 1'b0;
      if (!rst_i && (state_q != WR_GAP) && !issue_write && (used < 8'(RSP_DEPTH))) begin
         req_ready_o = 1'b1;
      end
   end

   // Next TCAM port values: one access cycle per accept; addr/wmask/wdata hold otherwise
   always_comb begin
      csb_d = 1'b1;
      web_d = 1'b1;
      cmd_d = cmd_q;
      if (accept) begin
         csb_d     = 1'b0;
         web_d     = !req_we_i;
         cmd_d.we  = req_we_i;
         cmd_d.key = PORT_W'(req_key_i);
         if (req_we_i) begin
            cmd_d.wmask = req_wmask_i;
            cmd_d.wdata = PORT_W'(req_wdata_i);
         end else begin
            cmd_d.wmask = 4'h0;
         end
      end
   end

   // Search-valid pipe tagged at the end of the issue cycle; its tail marks result capture
   always_comb begin
      pipe_d[0] = issue_search;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Saturating statistics
   always_comb begin
      stat_search_d = stat_search_q;
      stat_hit_d    = stat_hit_q;
      if (issue_search && (stat_search_q != {CNT_W{1'b1}})) begin
         stat_search_d = stat_search_q + CNT_W'(1);
      end
      if (push && rsp_in.hit && (stat_hit_q != {CNT_W{1'b1}})) begin
         stat_hit_d = stat_hit_q + CNT_W'(1);
      end
   end

   // Datapath registers: TCAM port, in-flight pipe and statistics
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         csb_q         <= 1'b1;
         web_q         <= 1'b1;
         cmd_q         <= '0;
         pipe_q        <= '0;
         stat_search_q <= '0;
         stat_hit_q    <= '0;
      end else begin
         csb_q         <= csb_d;
         web_q         <= web_d;
         cmd_q         <= cmd_d;
         pipe_q        <= pipe_d;
         stat_search_q <= stat_search_d;
         stat_hit_q    <= stat_hit_d;
      end
   end

   assign rsp_in = decode_result(tcam_rdata_i);

   tcam_rsp_fifo #(
      .W     (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .din_i   (rsp_in),
      .pop_i   (rsp_valid_o && rsp_ready_i),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign rsp_out       = tcam_rsp_t'(fifo_dout);
   assign rsp_valid_o   = !fifo_empty;
   assign rsp_hit_o     = rsp_out.hit;
   assign rsp_index_o   = rsp_out.idx;
   assign rsp_err_o     = rsp_out.err;

   assign tcam_csb_o    = csb_q;
   assign tcam_web_o    = web_q;
   assign tcam_wmask_o  = cmd_q.wmask;
   assign tcam_addr_o   = cmd_q.key;
   assign tcam_wdata_o  = cmd_q.wdata[DATA_W-1:0];

   assign stat_search_o = stat_search_q;
   assign stat_hit_o    = stat_hit_q;
   // fifo_full is part of the FIFO contract; credits keep it from gating anything here
   assign busy_o        = (inflight != 8'd0) || !fifo_empty || (fifo_full && 1'b0);

endmodule
